// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
// Bypass of empty queues is enabled with WB_BYPASS_EN.
package wb_pkg;

   localparam int XLEN      = 32;
   localparam int PRF_AW    = 6;
   localparam int NUM_UNITS = 4;
   localparam int NUM_WP    = 2;

   localparam int UNIT_ALU = 0;
   localparam int UNIT_SFU = 1;
   localparam int UNIT_BRU = 2;
   localparam int UNIT_AGU = 3;

   typedef struct packed {
      logic [XLEN-1:0]   data;
      logic [PRF_AW-1:0] rd;
   } wb_req_t;

endpackage

// File: rtl/wb_queue.sv
// Per-unit result FIFO: circular buffer with registered count.
// A synchronous clear discards contents and same-cycle pushes.
module wb_queue
   import wb_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    clear,
   input  logic    push,
   input  wb_req_t push_req,
   input  logic    pop,
   output wb_req_t head,
   output logic    empty,
   output logic    full
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH + 1);

   wb_req_t         mem [QDEPTH];
   logic [PW-1:0]   hd;
   logic [PW-1:0]   tl;
   logic [CW-1:0]   count;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(QDEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[hd];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hd    <= '0;
         tl    <= '0;
         count <= '0;
      end else if (clear) begin
         hd    <= '0;
         tl    <= '0;
         count <= '0;
      end else begin
         if (do_push)
            tl <= tl + PW'(1);
         if (do_pop)
            hd <= hd + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[tl] <= push_req;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: four unit queues, two RF write ports, round-robin.
// Define WB_BYPASS_EN to let a result skip its empty queue.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              recover,
   input  logic [XLEN-1:0]   aluoutw,
   input  logic [XLEN-1:0]   sfuoutw,
   input  logic [XLEN-1:0]   bruoutw,
   input  logic [XLEN-1:0]   aguoutw,
   input  logic [PRF_AW-1:0] alurdw,
   input  logic [PRF_AW-1:0] sfurdw,
   input  logic [PRF_AW-1:0] brurdw,
   input  logic [PRF_AW-1:0] agurdw,
   input  logic              aluenw,
   input  logic              sfuenw,
   input  logic              bruenw,
   input  logic              aguenw,
   output logic              we0,
   output logic              we1,
   output logic [PRF_AW-1:0] wa0,
   output logic [PRF_AW-1:0] wa1,
   output logic [XLEN-1:0]   wd0,
   output logic [XLEN-1:0]   wd1,
   output logic              stall
);

   wb_req_t              in_req   [NUM_UNITS];
   wb_req_t              q_head   [NUM_UNITS];
   wb_req_t              cand_req [NUM_UNITS];
   logic [NUM_UNITS-1:0] in_en;
   logic [NUM_UNITS-1:0] enq_ok;
   logic [NUM_UNITS-1:0] byp;
   logic [NUM_UNITS-1:0] cand;
   logic [NUM_UNITS-1:0] grant;
   logic [NUM_UNITS-1:0] q_push;
   logic [NUM_UNITS-1:0] q_pop;
   logic [NUM_UNITS-1:0] q_empty;
   logic [NUM_UNITS-1:0] q_full;
   logic [1:0]           rr;
   logic [1:0]           rr_nxt;
   logic [1:0]           u0;
   logic [1:0]           u1;
   logic [1:0]           last;
   logic [1:0]           idx;
   logic                 g0;
   logic                 g1;

   assign in_req[UNIT_ALU] = '{data: aluoutw, rd: alurdw};
   assign in_req[UNIT_SFU] = '{data: sfuoutw, rd: sfurdw};
   assign in_req[UNIT_BRU] = '{data: bruoutw, rd: brurdw};
   assign in_req[UNIT_AGU] = '{data: aguoutw, rd: agurdw};
   assign in_en = {aguenw, bruenw, sfuenw, aluenw};

   assign stall = |q_full;

   always_comb begin
      for (int u = 0; u < NUM_UNITS; u++) begin
         enq_ok[u] = in_en[u] && (in_req[u].rd != '0)
                     && !stall && !recover;
      end
   end

`ifdef WB_BYPASS_EN
   always_comb begin
      for (int u = 0; u < NUM_UNITS; u++)
         byp[u] = enq_ok[u] && q_empty[u] && !rst;
   end
`else
   assign byp = '0;
`endif

   always_comb begin
      for (int u = 0; u < NUM_UNITS; u++) begin
         cand[u]     = !q_empty[u] || byp[u];
         cand_req[u] = q_empty[u] ? in_req[u] : q_head[u];
      end
   end

   // Circular scan from rr: first candidate to port 0, second to port 1.
   always_comb begin
      g0    = 1'b0;
      g1    = 1'b0;
      u0    = '0;
      u1    = '0;
      last  = rr;
      idx   = rr;
      grant = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         idx = rr + 2'(k);
         if (cand[idx]) begin
            if (!g0) begin
               g0         = 1'b1;
               u0         = idx;
               grant[idx] = 1'b1;
               last       = idx;
            end else if (!g1) begin
               g1         = 1'b1;
               u1         = idx;
               grant[idx] = 1'b1;
               last       = idx;
            end
         end
      end
      rr_nxt = (g0 || g1) ? last + 2'd1 : rr;
   end

   assign q_pop  = grant & ~q_empty;
   assign q_push = enq_ok & ~(grant & byp);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr <= '0;
      else if (!recover)
         rr <= rr_nxt;
   end

   assign we0 = g0;
   assign we1 = g1;
   assign wa0 = g0 ? cand_req[u0].rd   : '0;
   assign wd0 = g0 ? cand_req[u0].data : '0;
   assign wa1 = g1 ? cand_req[u1].rd   : '0;
   assign wd1 = g1 ? cand_req[u1].data : '0;

   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_q
      wb_queue #(
         .QDEPTH(QDEPTH)
      ) u_q (
         .clk      (clk),
         .rst      (rst),
         .clear    (recover),
         .push     (q_push[u]),
         .push_req (in_req[u]),
         .pop      (q_pop[u]),
         .head     (q_head[u]),
         .empty    (q_empty[u]),
         .full     (q_full[u])
      );
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (default build, QDEPTH=2).
// Every write is matched against a scoreboard of accepted results.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        recover = 1'b0;
   logic [31:0] d [4];
   logic [5:0]  r [4];
   logic        e [4];
   logic        we0, we1, stall;
   logic [5:0]  wa0, wa1;
   logic [31:0] wd0, wd1;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [37:0] pool [$];
   bit          fair_on = 1'b0;
   bit          prev_ok = 1'b0;
   logic [3:0]  prev_mask = '0;

   always #5 clk = ~clk;

   wb_arbiter #(.QDEPTH(2)) dut (
      .clk(clk), .rst(rst), .recover(recover),
      .aluoutw(d[0]), .sfuoutw(d[1]),
      .bruoutw(d[2]), .aguoutw(d[3]),
      .alurdw(r[0]), .sfurdw(r[1]),
      .brurdw(r[2]), .agurdw(r[3]),
      .aluenw(e[0]), .sfuenw(e[1]),
      .bruenw(e[2]), .aguenw(e[3]),
      .we0(we0), .we1(we1),
      .wa0(wa0), .wa1(wa1),
      .wd0(wd0), .wd1(wd1),
      .stall(stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit take(input logic [37:0] w);
      foreach (pool[i]) begin
         if (pool[i] == w) begin
            pool.delete(i);
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic int unit_of(input logic [5:0] a);
      return (int'(a) - 1) / 10;
   endfunction

   task automatic mon();
      logic [3:0] m;
      m = '0;
      if (we0) begin
         chk("port0 write in scoreboard", 32'(take({wa0, wd0})), 1);
         if (fair_on) m[2'(unit_of(wa0))] = 1'b1;
      end else begin
         chk("port0 idle addr", 32'(wa0), 0);
         chk("port0 idle data", wd0, 0);
      end
      if (we1) begin
         chk("port1 write in scoreboard", 32'(take({wa1, wd1})), 1);
         if (fair_on) m[2'(unit_of(wa1))] = 1'b1;
      end else begin
         chk("port1 idle addr", 32'(wa1), 0);
         chk("port1 idle data", wd1, 0);
      end
      if (!fair_on) begin
         prev_ok = 1'b0;
      end else if (m != '0) begin
         if (prev_ok) chk("fairness two cycles", 32'(prev_mask | m), 32'hf);
         prev_mask = m;
         prev_ok   = 1'b1;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) mon();
      end
   end

   task automatic set_in(input int u, input logic en,
                         input logic [5:0] rd, input logic [31:0] data);
      e[u] = en;
      r[u] = rd;
      d[u] = data;
   endtask

   task automatic clr_in();
      for (int u = 0; u < 4; u++) set_in(u, 1'b0, 6'd0, 32'd0);
   endtask

   // Upstream handshake: inputs are taken when stall and recover are low.
   task automatic note_accept();
      if (!stall && !recover && !rst) begin
         for (int u = 0; u < 4; u++)
            if (e[u] && r[u] != 6'd0) pool.push_back({r[u], d[u]});
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
      note_accept();
   endtask

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      recover = 1'b0;
      clr_in();
      pool.delete();
      fair_on = 1'b0;
      to_drive();
      rst = 1'b0;
   endtask

   task automatic drained(input string tag);
      for (int i = 0; i < 10 && pool.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      chk(tag, pool.size(), 0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " we0"}, 32'(we0), 0);
      chk({tag, " we1"}, 32'(we1), 0);
      chk({tag, " wa0"}, 32'(wa0), 0);
      chk({tag, " wa1"}, 32'(wa1), 0);
      chk({tag, " wd0"}, wd0, 0);
      chk({tag, " wd1"}, wd1, 0);
      chk({tag, " stall"}, 32'(stall), 0);
   endtask

   task automatic load_batch(input int b);
      for (int u = 0; u < 4; u++)
         set_in(u, 1'b1, 6'(1 + u * 10 + b), 32'hA000_0000 + 32'(u * 256 + b));
   endtask

   initial begin
      int         b;
      int         cyc;
      bit         acc;
      bit         stall_seen;
      logic [2:0] st_exp;

      clr_in();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      to_neg();
      chk_idle("reset");
      to_drive();

      set_in(0, 1'b1, 6'd5, 32'h1234);
      to_neg();
      chk("single no same-cycle write", 32'(we0), 0);
      to_drive();
      clr_in();
      to_neg();
      chk("single we0", 32'(we0), 1);
      chk("single wa0", 32'(wa0), 5);
      chk("single wd0", wd0, 32'h1234);
      chk("single we1", 32'(we1), 0);
      to_drive();
      drained("single drained");

      do_reset();
      for (int u = 0; u < 4; u++)
         set_in(u, 1'b1, 6'(u + 1), 32'h100 + 32'(u + 1));
      to_neg();
      to_drive();
      clr_in();
      to_neg();
      chk("all4 c1 wa0", 32'(wa0), 1);
      chk("all4 c1 wa1", 32'(wa1), 2);
      to_drive();
      to_neg();
      chk("all4 c2 wa0", 32'(wa0), 3);
      chk("all4 c2 wa1", 32'(wa1), 4);
      to_drive();
      set_in(0, 1'b1, 6'd9, 32'h909);
      set_in(2, 1'b1, 6'd10, 32'h1010);
      to_neg();
      to_drive();
      clr_in();
      to_neg();
      chk("rr back at 0 wa0", 32'(wa0), 9);
      chk("rr back at 0 wa1", 32'(wa1), 10);
      to_drive();
      drained("all4 drained");

      do_reset();
      set_in(3, 1'b1, 6'd0, 32'hDEAD);
      to_neg();
      to_drive();
      clr_in();
      for (int i = 0; i < 4; i++) begin
         to_neg();
         chk("rd0 no we0", 32'(we0), 0);
         chk("rd0 no we1", 32'(we1), 0);
         to_drive();
      end

      do_reset();
      fair_on = 1'b1;
      b = 0;
      cyc = 0;
      stall_seen = 1'b0;
      st_exp = 3'b100;
      load_batch(0);
      while (b < 10 && cyc < 100) begin
         to_neg();
         if (cyc < 3) chk("stream stall timing", 32'(stall), 32'(st_exp[cyc]));
         if (stall) stall_seen = 1'b1;
         acc = !stall;
         to_drive();
         cyc++;
         if (acc) begin
            b++;
            if (b < 10) load_batch(b);
            else clr_in();
         end
      end
      fair_on = 1'b0;
      chk("stream batches taken", b, 10);
      chk("stream stall seen", 32'(stall_seen), 1);
      drained("stream no loss");

      do_reset();
      set_in(0, 1'b1, 6'd11, 32'hB0B0_0011);
      set_in(1, 1'b1, 6'd12, 32'hB0B0_0012);
      set_in(2, 1'b1, 6'd13, 32'hB0B0_0013);
      to_neg();
      to_drive();
      clr_in();
      recover = 1'b1;
      to_neg();
      chk("recover cycle we0", 32'(we0), 1);
      chk("recover cycle wa0", 32'(wa0), 11);
      chk("recover cycle we1", 32'(we1), 1);
      chk("recover cycle wa1", 32'(wa1), 12);
      to_drive();
      recover = 1'b0;
      chk("recover flushed one", pool.size(), 1);
      pool.delete();
      for (int i = 0; i < 3; i++) begin
         to_neg();
         chk("after recover we0", 32'(we0), 0);
         chk("after recover we1", 32'(we1), 0);
         chk("after recover stall", 32'(stall), 0);
         to_drive();
      end

      do_reset();
      for (int k = 0; k < 2; k++) begin
         for (int u = 0; u < 4; u++)
            set_in(u, 1'b1, 6'(21 + k * 4 + u), 32'hC000_0000 + 32'(k * 4 + u));
         to_neg();
         to_drive();
      end
      clr_in();
      recover = 1'b1;
      to_neg();
      chk("recover+stall stall", 32'(stall), 1);
      chk("recover+stall wa0", 32'(wa0), 23);
      chk("recover+stall wa1", 32'(wa1), 24);
      to_drive();
      recover = 1'b0;
      chk("recover+stall flushed", pool.size(), 4);
      pool.delete();
      to_neg();
      chk("recover wins stall", 32'(stall), 0);
      chk("recover wins we0", 32'(we0), 0);
      chk("recover wins we1", 32'(we1), 0);
      to_drive();

      do_reset();
      for (int k = 0; k < 2; k++) begin
         for (int u = 0; u < 4; u++)
            set_in(u, 1'b1, 6'(31 + k * 4 + u), 32'hD000_0000 + 32'(k * 4 + u));
         to_neg();
         to_drive();
      end
      clr_in();
      to_neg();
      chk("pre-rst stall", 32'(stall), 1);
      chk("pre-rst we0", 32'(we0), 1);
      #2;
      rst = 1'b1;
      pool.delete();
      #1;
      chk_idle("async rst");
      to_drive();
      rst = 1'b0;
      to_neg();
      chk("post-rst we0", 32'(we0), 0);
      chk("post-rst stall", 32'(stall), 0);
      to_drive();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the EX/WB pipeline register and the physical register file. It accepts up to four results per cycle (ALU, SFU, BRU link value, AGU) and buffers each in a small per-unit queue. It grants at most two results per cycle to the register file's two write ports using round-robin order. It freezes the EX/WB register whenever any queue is full.

## Interface
- QDEPTH, 2: entries per unit queue; legal values are 2 or 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- recover  in  1  synchronous flush of all queued results (mispredict or exception).
- aluoutw / sfuoutw / bruoutw / aguoutw  in  32 each  result data per unit.
- alurdw / sfurdw / brurdw / agurdw  in  6 each  destination physical register per unit.
- aluenw / sfuenw / bruenw / aguenw  in  1 each  result valid per unit.
- we0, we1  out  1 each  register file write enables, ports 0 and 1.
- wa0, wa1  out  6 each  write addresses.
- wd0, wd1  out  32 each  write data.
- stall  out  1  freeze request to the EX/WB register and the upstream pipeline.

## Operation
- Unit index and round-robin order: ALU=0, SFU=1, BRU=2, AGU=3.
- Enqueue condition for unit u: en_u=1, rd_u≠0, stall=0, recover=0.
  - Results with rd=0 are dropped silently.
  - While stall=1, inputs are ignored; upstream holds them and they enqueue once, in the first cycle stall is 0.
- Each queue is FIFO, QDEPTH entries, with registered count.
  - Enqueue and dequeue may occur in the same cycle; count is unchanged and no data is lost.
- Grant:
  - Scan the 4 queue heads starting at pointer rr, in circular order.
  - The first non-empty head goes to port 0; the second non-empty head goes to port 1.
  - Every granted head is dequeued at the edge.
- Pointer update:
  - rr ← (index of last granted unit + 1) mod 4.
  - rr is unchanged if nothing is granted.
- stall = OR over units of (count_u == QDEPTH). It is a function of registered state only.
- recover:
  - At the edge, all counts are cleared and same-cycle inputs are discarded.
  - Grants in the recover cycle still drive we0/we1; the writes occur.
  - rr is unchanged.
- Addresses are not compared across ports; renaming guarantees distinct destinations.
- When weN=0, waN=0 and wdN=0.

## Timing
- Reset values: we0=we1=0, wa0=wa1=0, wd0=wd1=0, stall=0, rr=0, all queues empty.
- Latency without bypass:
  - A result is valid at the input in cycle N and enqueued at the end of N.
  - At the earliest, it is granted combinationally in N+1 and written to the register file at the end of N+1.
- Throughput: 2 writes per cycle sustained. With 4 inputs every cycle, queues fill and stall asserts.
- stall timing:
  - stall rises the cycle after a queue reaches full.
  - stall falls in the cycle after the full queue is granted.
- Reset asserted mid-operation: all state clears immediately, without waiting for the clock.
- Simultaneous recover and stall: recover wins; queues are cleared and stall is 0 in the next cycle.

## Configuration
- WB_BYPASS_EN defined:
  - An input that meets the enqueue condition, arrives at an empty queue, and would win a port in round-robin order against the queue heads is driven to that port in the same cycle.
  - That input is not enqueued; latency is 0.
- WB_BYPASS_EN undefined: every result passes through its queue; minimum latency is 1 cycle.

## Structure
- Package wb_pkg holds:
  - constants XLEN=32, PRF_AW=6, NUM_UNITS=4, NUM_WP=2;
  - unit index localparams UNIT_ALU, UNIT_SFU, UNIT_BRU, UNIT_AGU;
  - typedef wb_req_t {data[XLEN], rd[PRF_AW]}.
- Sub-module wb_queue (parameter QDEPTH): a circular buffer with head/tail pointers and count. It exposes push, pop, head, empty and full, and has a synchronous clear input driven by recover. wb_arbiter instantiates it four times.

## Test plan
- Reset, then single ALU result rd=5, data=0x1234 in cycle 1:
  - Expect we0=1, wa0=5, wd0=0x1234 in cycle 2 (cycle 1 if WB_BYPASS_EN); we1=0.
- All four units valid, rd=1..4, for one cycle:
  - Cycle +1: ports carry rd 1 and 2.
  - Cycle +2: ports carry rd 3 and 4.
  - rr returns to 0.
- All four units valid every cycle for 10 cycles, QDEPTH=2:
  - stall asserts.
  - Each result is written exactly once, with no loss or duplication.
  - Every unit is granted within any 2 consecutive granting cycles.
- AGU result with rd=0, data=0xDEAD: no write ever occurs.
- Queues holding 3 results, recover pulsed:
  - Recover cycle: its grants write.
  - Next cycle: we0=we1=0 and stall=0.
- rst asserted asynchronously mid-stream with a full queue: outputs go to 0 immediately and stall drops without waiting for a clock edge.
